// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MDBUSY = 1'b1
    } state_t;

    localparam int MD_LAT_DEFAULT = 32;

    // Bits needed to hold MD_LAT-1; never less than one bit.
    function automatic int cnt_width(input int lat);
        int w;
        w = $clog2(lat);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_lat_counter.sv
// Loadable down-counter that tracks the remaining mul/div cycles.
module lat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic         hold,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Hold wins over load/decrement so a memory stall freezes the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory stalls, load-use hazards,
// taken branches and a multi-cycle mul/div unit.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_branch_taken,
    input  logic       id_md_start,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       en_f,
    output logic       en_d,
    output logic       en_e,
    output logic       en_m,
    output logic       en_w,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       md_en,
    output logic       md_busy,
    output logic       md_done
);

    localparam int CW = cnt_width(MD_LAT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          cnt_load;
    logic          cnt_dec;
    logic          mem_stall;
    logic          load_use;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_memread & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign md_busy   = (state == MDBUSY);

    lat_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .hold     (mem_stall),
        .load_val (CW'(MD_LAT - 1)),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // A memory stall freezes every stage; otherwise the state decides.
    always_comb begin
        en_f     = 1'b1;
        en_d     = 1'b1;
        en_e     = 1'b1;
        en_m     = 1'b1;
        en_w     = 1'b1;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        md_en    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (mem_stall) begin
            en_f = 1'b0;
            en_d = 1'b0;
            en_e = 1'b0;
            en_m = 1'b0;
            en_w = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        en_f    = 1'b0;
                        en_d    = 1'b0;
                        flush_e = 1'b1;
                    end else begin
                        cnt_load = id_md_start;
                        flush_d  = id_branch_taken;
                    end
                end
                MDBUSY: begin
                    en_f    = 1'b0;
                    en_d    = 1'b0;
                    en_e    = 1'b0;
                    flush_m = 1'b1;
                    md_en   = 1'b1;
                    cnt_dec = ~cnt_zero;
                end
                default: ;
            endcase
        end
    end

    // md_done pulses in the cycle after the last mul/div cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            if (!mem_stall) begin
                case (state)
                    RUN: begin
                        if (!load_use && id_md_start) begin
                            state <= MDBUSY;
                        end
                    end
                    MDBUSY: begin
                        if (cnt_zero) begin
                            state   <= RUN;
                            md_done <= 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl at MD_LAT=4, with an MD_LAT=1 instance alongside.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, id_branch_taken, id_md_start, mem_req, mem_ready;

    logic en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m, md_en, md_busy, md_done;
    logic en_f1, en_d1, en_e1, en_m1, en_w1, flush_d1, flush_e1, flush_m1, md_en1, md_busy1, md_done1;

    int vecCount = 0;
    int errCount = 0;

    // Output vector order: en_f en_d en_e en_m en_w flush_d flush_e flush_m md_en md_busy md_done
    localparam logic [10:0] IDLE   = 11'b11111_000_0_0_0;
    localparam logic [10:0] DONE   = 11'b11111_000_0_0_1;
    localparam logic [10:0] LU     = 11'b00111_010_0_0_0;
    localparam logic [10:0] BR     = 11'b11111_100_0_0_0;
    localparam logic [10:0] STALL  = 11'b00000_000_0_0_0;
    localparam logic [10:0] MSTALL = 11'b00000_000_0_1_0;
    localparam logic [10:0] MDB    = 11'b00011_001_1_1_0;

    logic [10:0] outs, outs1;
    assign outs  = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m, md_en, md_busy, md_done};
    assign outs1 = {en_f1, en_d1, en_e1, en_m1, en_w1, flush_d1, flush_e1, flush_m1, md_en1, md_busy1, md_done1};

    pipe_ctrl #(.MD_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .id_branch_taken(id_branch_taken), .id_md_start(id_md_start),
        .mem_req(mem_req), .mem_ready(mem_ready), .en_f(en_f), .en_d(en_d), .en_e(en_e),
        .en_m(en_m), .en_w(en_w), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .md_en(md_en), .md_busy(md_busy), .md_done(md_done)
    );

    pipe_ctrl #(.MD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .id_branch_taken(id_branch_taken), .id_md_start(id_md_start),
        .mem_req(mem_req), .mem_ready(mem_ready), .en_f(en_f1), .en_d(en_d1), .en_e(en_e1),
        .en_m(en_m1), .en_w(en_w1), .flush_d(flush_d1), .flush_e(flush_e1), .flush_m(flush_m1),
        .md_en(md_en1), .md_busy(md_busy1), .md_done(md_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [10:0] observed, input logic [10:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic memread, input logic [4:0] exrt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic br, input logic md,
                                 input logic mreq, input logic mrdy, input logic r);
        ex_memread      = memread;
        ex_rt           = exrt;
        id_rs           = rs;
        id_rt           = rt;
        id_branch_taken = br;
        id_md_start     = md;
        mem_req         = mreq;
        mem_ready       = mrdy;
        rst             = r;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs are applied 1 unit after a rising edge; outputs are sampled mid-cycle.
    task automatic runVec(input string tag, input logic [10:0] expected);
        #4;
        checkOutput(tag, outs, expected);
        @(posedge clk);
        #1;
    endtask

    task automatic runVec2(input string tag, input logic [10:0] expected, input logic [10:0] expected1);
        #4;
        checkOutput(tag, outs, expected);
        checkOutput({tag, "_lat1"}, outs1, expected1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        runVec2("reset", IDLE, IDLE);
        idle();
        runVec("idle", IDLE);

        applyStimulus(1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("lu_rs", LU);
        idle();
        runVec("lu_after", IDLE);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("lu_r0", IDLE);
        applyStimulus(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("lu_rt_br", LU);

        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("branch", BR);
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        runVec("branch_stall", STALL);
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        runVec("branch_memrdy", BR);

        // Plain mul/div: 4 busy cycles, load-use and branch ignored while busy.
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec("md_accept", IDLE);
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("md_b1", MDB);
        idle();
        runVec("md_b2", MDB);
        runVec("md_b3", MDB);
        runVec("md_b4", MDB);
        runVec("md_done", DONE);
        runVec("md_after", IDLE);

        // Mul/div with a 3-cycle memory stall in the middle: 7 busy cycles.
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec("mds_accept", IDLE);
        idle();
        runVec("mds_b1", MDB);
        runVec("mds_b2", MDB);
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) runVec($sformatf("mds_stall%0d", i), MSTALL);
        idle();
        runVec("mds_b3", MDB);
        runVec("mds_b4", MDB);
        runVec("mds_done", DONE);

        // Load-use beats id_md_start; retry next cycle enters MDBUSY, then reset mid-op.
        applyStimulus(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec("lu_md", LU);
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec("md_retry", IDLE);
        idle();
        runVec("rst_b1", MDB);
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        runVec("rst_b2", MDB);
        idle();
        runVec2("rst_run", IDLE, IDLE);
        runVec("rst_nodone", IDLE);

        // Simultaneous mul/div and branch; MD_LAT=1 instance finishes after one busy cycle.
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec2("mdbr_accept", BR, BR);
        idle();
        runVec2("mdbr_b1", MDB, MDB);
        runVec2("mdbr_b2", MDB, DONE);
        runVec2("mdbr_b3", MDB, IDLE);
        runVec("mdbr_b4", MDB);
        runVec("mdbr_done", DONE);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MD_LAT, default 32, mul/div latency in cycles (legal 1..64).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-005 ex_memread  in  1  instruction in EX is a load.
REQ-006 ex_rt  in  5  load destination register in EX.
REQ-007 id_branch_taken  in  1  branch or jump in ID resolved as taken.
REQ-008 id_md_start  in  1  instruction in ID requests a mul/div.
REQ-009 mem_req, mem_ready  in  1 each  MEM-stage access pending / access complete.
REQ-010 en_f, en_d, en_e, en_m, en_w  out  1 each  enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-011 flush_d, flush_e, flush_m  out  1 each  clear IF/ID, ID/EX and EX/MEM to a bubble.
REQ-012 md_en  out  1  advance the mul/div unit this cycle.
REQ-013 md_busy  out  1  mul/div in progress; md_done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states: RUN, MDBUSY. Down-counter cnt is ceil(log2(MD_LAT)) bits, minimum 1.
REQ-015 mem_stall = mem_req & !mem_ready. It has the highest priority in every state.
REQ-016 While mem_stall: all en_* = 0, all flush_* = 0, md_en = 0, and state and cnt hold.
REQ-017 load_use = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
REQ-018 RUN, no mem_stall, load_use: en_f = en_d = 0, flush_e = 1, other enables 1. id_md_start and id_branch_taken are ignored this cycle.
REQ-019 RUN, no mem_stall, no load_use, id_md_start: accept the request. Next state is MDBUSY, cnt loads MD_LAT-1, and outputs are all en_* = 1 with no flush.
REQ-020 RUN, no stall, id_branch_taken and no id_md_start: flush_d = 1, all en_* = 1.
REQ-021 id_md_start and id_branch_taken together in RUN: the mul/div is accepted and flush_d = 1.
REQ-022 MDBUSY, no mem_stall outputs: en_f = en_d = en_e = 0, en_m = en_w = 1, flush_m = 1, md_en = 1.
REQ-023 MDBUSY, no mem_stall, cnt != 0: cnt decrements.
REQ-024 MDBUSY, no mem_stall, cnt == 0: next state is RUN and md_done is 1 in the following cycle.
REQ-025 load_use and id_branch_taken are ignored in MDBUSY.
REQ-026 md_busy = (state == MDBUSY). md_done is registered and lasts exactly one cycle.
REQ-027 MD_LAT = 1: MDBUSY lasts exactly one unstalled cycle.
REQ-028 Total MDBUSY residency = MD_LAT + (number of mem_stall cycles during it).
REQ-029 RUN, no conditions active: all en_* = 1, all flush_* = 0, md_en = 0.

Reset
REQ-030 When rst is sampled high: state becomes RUN, cnt becomes 0 and md_done becomes 0, regardless of mem_stall.
REQ-031 rst during MDBUSY abandons the operation with no md_done pulse.
REQ-032 From the cycle after rst, outputs take the RUN values defined by the current inputs.

Structure
REQ-033 The shared package pipe_ctrl_pkg shall hold the state enum (RUN, MDBUSY), the MD_LAT default and the counter-width function.
REQ-034 The counter shall be one sub-module, lat_counter, with load, decrement and hold controls, a zero flag and a synchronous reset.
REQ-035 All en_*/flush_*/md_en outputs shall be combinational from state, cnt and the inputs. md_done is the only registered output.

Verification
REQ-036 Load-use: ex_memread = 1, ex_rt = 5, id_rs = 5 -> one cycle with en_f = en_d = 0, flush_e = 1. ex_rt = 0 with id_rs = 0 -> no stall.
REQ-037 MD_LAT = 4, id_md_start pulse -> md_busy high for 4 cycles with flush_m = 1 and en_e = 0, then md_done = 1 for 1 cycle, then RUN.
REQ-038 Mul/div with MD_LAT = 4 plus mem_req = 1, mem_ready = 0 for 3 cycles mid-operation -> all en_* = 0 and cnt frozen during the stall, md_busy high for 7 cycles in total.
REQ-039 Simultaneous load_use and id_md_start -> load-use stall only, no MDBUSY. Repeating id_md_start with load_use = 0 next cycle -> MDBUSY entered.
REQ-040 rst asserted on the 2nd MDBUSY cycle -> RUN next cycle, md_done stays 0, all en_* = 1.
REQ-041 id_branch_taken = 1 in RUN -> flush_d = 1, all en_* = 1. The same during mem_stall -> flush_d = 0.
